// File: rtl/t_bird_tail_light_pkg.sv
// Shared types for the T-Bird tail-light decoder.
//   lamp_pat_e  : the eight legal 6-bit lamp codes, bit order {LA,LB,LC,RA,RB,RC}
//   mode_e      : decoded command reported on the mode output
//   dec_state_e : decoder FSM state (one per legal code, plus UNKNOWN)
package t_bird_tail_light_pkg;

  typedef enum logic [5:0] {
    PAT_OFF = 6'b000_000,
    PAT_L1  = 6'b100_000,
    PAT_L2  = 6'b110_000,
    PAT_L3  = 6'b111_000,
    PAT_R1  = 6'b000_100,
    PAT_R2  = 6'b000_110,
    PAT_R3  = 6'b000_111,
    PAT_ALL = 6'b111_111
  } lamp_pat_e;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_e;

  typedef enum logic [3:0] {
    ST_OFF, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_ALL, ST_UNKNOWN
  } dec_state_e;

  // Registered response bundle of the decoder.
  typedef struct packed {
    mode_e mode;
    logic  seq_done;
    logic  step_err;
    logic  time_err;
  } dec_out_t;

  // Map a raw lamp pattern to the state it represents; illegal codes map to UNKNOWN.
  function automatic dec_state_e pat2state(input logic [5:0] p);
    case (p)
      PAT_OFF: pat2state = ST_OFF;
      PAT_L1:  pat2state = ST_L1;
      PAT_L2:  pat2state = ST_L2;
      PAT_L3:  pat2state = ST_L3;
      PAT_R1:  pat2state = ST_R1;
      PAT_R2:  pat2state = ST_R2;
      PAT_R3:  pat2state = ST_R3;
      PAT_ALL: pat2state = ST_ALL;
      default: pat2state = ST_UNKNOWN;
    endcase
  endfunction

  // Allowed moves between legal states. Self-loops and drops to OFF are always fine.
  function automatic logic step_ok(input dec_state_e cur, input dec_state_e nxt);
    step_ok = 1'b0;
    if (nxt == cur || nxt == ST_OFF) step_ok = 1'b1;
    else begin
      case (cur)
        ST_OFF:  step_ok = (nxt == ST_L1) || (nxt == ST_R1) || (nxt == ST_ALL);
        ST_L1:   step_ok = (nxt == ST_L2);
        ST_L2:   step_ok = (nxt == ST_L3);
        ST_R1:   step_ok = (nxt == ST_R2);
        ST_R2:   step_ok = (nxt == ST_R3);
        default: step_ok = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/t_bird_dwell_counter.sv
// Pattern-change detector plus saturating dwell counter.
//   clk, rst   : clock, synchronous active-high reset
//   i_vld      : i_pat holds a real sample this cycle
//   i_pat      : sampled lamp pattern
//   o_prev     : previously accepted pattern
//   o_cnt      : run length of o_prev (0 right after reset, saturates at DWELL_CYCLES+1)
//   o_changed  : i_pat starts a new run (always true for the first sample after reset)
module t_bird_dwell_counter #(
  parameter int DWELL_CYCLES = 4,
  parameter int CW           = $clog2(DWELL_CYCLES + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vld,
  input  logic [5:0]    i_pat,
  output logic [5:0]    o_prev,
  output logic [CW-1:0] o_cnt,
  output logic          o_changed
);

  localparam logic [CW-1:0] C_SAT = CW'(DWELL_CYCLES + 1);

  logic [5:0]    r_prev;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // r_cnt == 0 only straight after reset, so the first sample always counts as a change.
  assign o_changed = (r_cnt == '0) || (i_pat != r_prev);
  assign w_cnt_nxt = o_changed        ? CW'(1) :
                     (r_cnt == C_SAT) ? C_SAT  : r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else if (i_vld) begin
      r_prev <= i_pat;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign o_prev = r_prev;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/t_bird_tail_light_decoder.sv
// Watches the six tail-light lamp drives and decodes the turn/hazard command,
// flagging illegal codes, illegal steps and wrong dwell times.
//   clk, rst           : clock, synchronous active-high reset
//   LA..RC             : observed lamp drives, P = {LA,LB,LC,RA,RB,RC}
//   mode               : IDLE/LEFT/RIGHT/HAZ
//   seq_done           : pulse when a full sequence (L3, R3, ALL) drops to OFF
//   step_err, time_err : pulses for step and dwell violations
//   err_cnt            : saturating count of error events
// Lamps are registered on one edge and the response is registered on the next.
module t_bird_tail_light_decoder
  import t_bird_tail_light_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       LA,
  input  logic       LB,
  input  logic       LC,
  input  logic       RA,
  input  logic       RB,
  input  logic       RC,
  output logic [1:0] mode,
  output logic       seq_done,
  output logic       step_err,
  output logic       time_err,
  output logic [7:0] err_cnt
);

  localparam int            CW  = $clog2(DWELL_CYCLES + 2);
  localparam logic [CW-1:0] C_D = CW'(DWELL_CYCLES);

  logic [5:0]    r_pat;
  logic          r_vld;
  dec_state_e    r_state, w_state_nxt;
  dec_out_t      r_out, w_out_nxt;
  logic [7:0]    r_err, w_err_nxt;

  logic [5:0]    w_prev;
  logic [CW-1:0] w_cnt;
  logic          w_changed;
  dec_state_e    w_pat_st;
  logic [1:0]    w_inc;

  // Input sample stage; r_vld masks the empty slot right after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat <= '0;
      r_vld <= 1'b0;
    end else begin
      r_pat <= {LA, LB, LC, RA, RB, RC};
      r_vld <= 1'b1;
    end
  end

  t_bird_dwell_counter #(.DWELL_CYCLES(DWELL_CYCLES), .CW(CW)) u_dwell (
    .clk       (clk),
    .rst       (rst),
    .i_vld     (r_vld),
    .i_pat     (r_pat),
    .o_prev    (w_prev),
    .o_cnt     (w_cnt),
    .o_changed (w_changed)
  );

  assign w_pat_st = pat2state(r_pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_out   <= '{mode: MODE_IDLE, seq_done: 1'b0, step_err: 1'b0, time_err: 1'b0};
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_out_nxt          = r_out;
    w_out_nxt.seq_done = 1'b0;
    w_out_nxt.step_err = 1'b0;
    w_out_nxt.time_err = 1'b0;
    w_inc              = 2'd0;
    w_err_nxt          = r_err;

    if (r_vld) begin
      // Step checking. UNKNOWN swallows everything until the lamps go dark.
      if (r_state == ST_UNKNOWN) begin
        if (r_pat == PAT_OFF) w_state_nxt = ST_OFF;
      end else if (w_pat_st == ST_UNKNOWN || !step_ok(r_state, w_pat_st)) begin
        w_out_nxt.step_err = 1'b1;
        w_state_nxt        = ST_UNKNOWN;
      end else begin
        w_state_nxt = w_pat_st;
      end

      // Dwell checking: a lit pattern must change exactly after DWELL_CYCLES
      // samples unless it drops to OFF; overstaying is flagged once.
      if (w_changed) begin
        if (w_cnt != '0 && w_prev != PAT_OFF && r_pat != PAT_OFF && w_cnt != C_D)
          w_out_nxt.time_err = 1'b1;
      end else if (r_pat != PAT_OFF && w_cnt == C_D) begin
        w_out_nxt.time_err = 1'b1;
      end

      w_out_nxt.seq_done = (r_pat == PAT_OFF) &&
                           (r_state == ST_L3 || r_state == ST_R3 || r_state == ST_ALL);

      if (w_out_nxt.step_err) begin
        w_out_nxt.mode = MODE_IDLE;
      end else if (w_state_nxt != r_state) begin
        case (w_state_nxt)
          ST_L1:   w_out_nxt.mode = MODE_LEFT;
          ST_R1:   w_out_nxt.mode = MODE_RIGHT;
          ST_ALL:  w_out_nxt.mode = MODE_HAZ;
          default: w_out_nxt.mode = r_out.mode;
        endcase
      end else if (r_pat == PAT_OFF && !w_changed && w_cnt == C_D) begin
        // OFF just reached DWELL_CYCLES+1: the sequence is over.
        w_out_nxt.mode = MODE_IDLE;
      end

      w_inc = {1'b0, w_out_nxt.step_err} + {1'b0, w_out_nxt.time_err};
      if (r_err > (8'd255 - {6'd0, w_inc})) w_err_nxt = 8'd255;
      else                                  w_err_nxt = r_err + {6'd0, w_inc};
    end
  end

  assign mode     = r_out.mode;
  assign seq_done = r_out.seq_done;
  assign step_err = r_out.step_err;
  assign time_err = r_out.time_err;
  assign err_cnt  = r_err;

endmodule

// File: tb/tb_t_bird_tail_light_decoder.sv
module tb_t_bird_tail_light_decoder;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic LA = 0, LB = 0, LC = 0, RA = 0, RB = 0, RC = 0;
  logic [1:0] mode;
  logic seq_done, step_err, time_err;
  logic [7:0] err_cnt;

  t_bird_tail_light_decoder #(.DWELL_CYCLES(D)) dut (
    .clk(clk), .rst(rst),
    .LA(LA), .LB(LB), .LC(LC), .RA(RA), .RB(RB), .RC(RC),
    .mode(mode), .seq_done(seq_done), .step_err(step_err), .time_err(time_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [5:0] OFF = 6'b000_000, L1 = 6'b100_000, L2 = 6'b110_000,
                         L3 = 6'b111_000, R1 = 6'b000_100, R2 = 6'b000_110,
                         R3 = 6'b000_111, ALL = 6'b111_111;

  // ---------------- reference model ----------------
  // Lamps are viewed as (side, level): side 0 none, 1 left, 2 right, 3 hazard;
  // level is the thermometer depth 1..3 (hazard counts as level 3).
  int         m_side, m_lvl;
  bit         m_unk;
  logic [5:0] m_prev;
  int         m_run;
  int         m_mode, m_err;
  bit         p_vld;
  int         p_mode, p_err;
  bit         p_sd, p_se, p_te;
  int         e_mode, e_err;
  bit         e_sd, e_se, e_te;

  function automatic int thermo(input logic [2:0] x);
    case (x)
      3'b000: return 0;
      3'b100: return 1;
      3'b110: return 2;
      3'b111: return 3;
      default: return -1;
    endcase
  endfunction

  // Returns 1 if legal, with side/level decoded.
  function automatic bit decode(input logic [5:0] p, output int side, output int lvl);
    int l, r;
    l = thermo(p[5:3]); r = thermo(p[2:0]);
    side = 0; lvl = 0;
    if (l == 0 && r == 0) return 1;
    if (l == 3 && r == 3) begin side = 3; lvl = 3; return 1; end
    if (l > 0 && r == 0) begin side = 1; lvl = l; return 1; end
    if (l == 0 && r > 0) begin side = 2; lvl = r; return 1; end
    return 0;
  endfunction

  task automatic model_reset();
    m_side = 0; m_lvl = 0; m_unk = 0; m_prev = 0; m_run = 0; m_mode = 0; m_err = 0;
    p_vld = 0; e_mode = 0; e_err = 0; e_sd = 0; e_se = 0; e_te = 0;
  endtask

  task automatic model_sample(input logic [5:0] p);
    bit chg, ok;
    int rp, s, l;
    chg = (m_run == 0) || (p != m_prev);
    rp  = m_run;
    p_sd = 0; p_se = 0; p_te = 0;
    if (chg && rp != 0 && m_prev != 0 && p != 0 && rp != D) p_te = 1;
    if (!chg && p != 0 && rp == D) p_te = 1;
    m_run  = chg ? 1 : ((rp + 1 > D + 1) ? D + 1 : rp + 1);
    m_prev = p;
    if (m_unk) begin
      if (p == 0) begin m_unk = 0; m_side = 0; m_lvl = 0; end
    end else if (!decode(p, s, l)) begin
      p_se = 1; m_unk = 1; m_mode = 0;
    end else begin
      ok = (s == m_side && l == m_lvl) || s == 0 ||
           (m_side == 0 && (l == 1 || s == 3)) ||
           (s == m_side && s != 3 && l == m_lvl + 1);
      if (ok) begin
        p_sd = (s == 0) && (m_lvl == 3);
        if (m_side == 0 && s != 0) m_mode = s;
        m_side = s; m_lvl = l;
      end else begin
        p_se = 1; m_unk = 1; m_mode = 0;
      end
    end
    if (!p_se && p == 0 && !chg && rp == D) m_mode = 0;
    m_err = m_err + int'(p_se) + int'(p_te);
    if (m_err > 255) m_err = 255;
    p_mode = m_mode; p_err = m_err; p_vld = 1;
  endtask

  // Drive one cycle of stimulus and advance the model to the post-edge view.
  task automatic cyc(input logic [5:0] p, input logic r);
    {LA, LB, LC, RA, RB, RC} = p;
    rst = r;
    @(posedge clk); #1;
    if (r) model_reset();
    else begin
      if (p_vld) begin
        e_mode = p_mode; e_err = p_err; e_sd = p_sd; e_se = p_se; e_te = p_te;
      end else begin
        e_sd = 0; e_se = 0; e_te = 0;
      end
      model_sample(p);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(6'($urandom), 1'b1);
      n_cmp++;
      if ({mode, seq_done, step_err, time_err, err_cnt} !== 13'd0) begin
        n_bad++;
        $display("FAIL reset cyc%0d got mode=%0d sd=%b se=%b te=%b err=%0d want all zero",
                 i, mode, seq_done, step_err, time_err, err_cnt);
      end
    end
  endtask

  task automatic test_left();
    logic [5:0] q[$];
    int sd_n = 0, first_l1 = 0;
    cyc(OFF, 1'b1);
    repeat (D) q.push_back(L1);
    repeat (D) q.push_back(L2);
    repeat (D) q.push_back(L3);
    repeat (D + 1) q.push_back(OFF);
    q.push_back(OFF);
    foreach (q[i]) begin
      cyc(q[i], 1'b0);
      n_cmp++;
      if ({mode, seq_done, step_err, time_err, err_cnt} !== {2'(e_mode), e_sd, e_se, e_te, 8'(e_err)}) begin
        n_bad++;
        $display("FAIL left cyc%0d got %0d/%b%b%b/%0d want %0d/%b%b%b/%0d", i,
                 mode, seq_done, step_err, time_err, err_cnt, e_mode, e_sd, e_se, e_te, e_err);
      end
      if (i == 1) first_l1 = mode;
      sd_n += int'(seq_done);
    end
    n_cmp++;
    if (first_l1 != 1 || sd_n != 1 || err_cnt !== 8'd0 || mode !== 2'd0) begin
      n_bad++;
      $display("FAIL left_summary got mode1=%0d sd=%0d err=%0d modeEnd=%0d want 1/1/0/0",
               first_l1, sd_n, err_cnt, mode);
    end
  endtask

  task automatic test_haz();
    logic [5:0] q[$];
    int sd_n = 0, haz_ok = 1;
    cyc(OFF, 1'b1);
    repeat (3) begin repeat (D) q.push_back(ALL); repeat (D) q.push_back(OFF); end
    q.push_back(OFF);
    foreach (q[i]) begin
      cyc(q[i], 1'b0);
      n_cmp++;
      if ({mode, seq_done, step_err, time_err, err_cnt} !== {2'(e_mode), e_sd, e_se, e_te, 8'(e_err)}) begin
        n_bad++;
        $display("FAIL haz cyc%0d got %0d/%b%b%b/%0d want %0d/%b%b%b/%0d", i,
                 mode, seq_done, step_err, time_err, err_cnt, e_mode, e_sd, e_se, e_te, e_err);
      end
      if (i >= 1 && mode !== 2'd3) haz_ok = 0;
      sd_n += int'(seq_done);
    end
    n_cmp++;
    if (!haz_ok || sd_n != 3 || err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL haz_summary got hazAll=%0d sd=%0d err=%0d want 1/3/0", haz_ok, sd_n, err_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] q[$];
    int se_n = 0;
    cyc(OFF, 1'b1);
    q.push_back(6'b101_000);
    repeat (D) q.push_back(OFF);
    q.push_back(L1); q.push_back(L1);
    foreach (q[i]) begin
      cyc(q[i], 1'b0);
      n_cmp++;
      if ({mode, seq_done, step_err, time_err, err_cnt} !== {2'(e_mode), e_sd, e_se, e_te, 8'(e_err)}) begin
        n_bad++;
        $display("FAIL illegal cyc%0d got %0d/%b%b%b/%0d want %0d/%b%b%b/%0d", i,
                 mode, seq_done, step_err, time_err, err_cnt, e_mode, e_sd, e_se, e_te, e_err);
      end
      if (i == 1 && mode !== 2'd0) begin n_bad++; $display("FAIL illegal_mode got %0d want 0", mode); end
      se_n += int'(step_err);
    end
    // Back in OFF, so the L1 afterwards is accepted.
    n_cmp++;
    if (se_n != 1 || err_cnt !== 8'd1 || mode !== 2'd1) begin
      n_bad++;
      $display("FAIL illegal_summary got se=%0d err=%0d mode=%0d want 1/1/1", se_n, err_cnt, mode);
    end
  endtask

  task automatic test_unknown();
    logic [5:0] q[$];
    int se_n = 0, te_n = 0;
    cyc(OFF, 1'b1);
    repeat (D) q.push_back(R1);
    repeat (D) q.push_back(R3);
    repeat (D) q.push_back(R2);
    repeat (D + 2) q.push_back(OFF);
    foreach (q[i]) begin
      cyc(q[i], 1'b0);
      n_cmp++;
      if ({mode, seq_done, step_err, time_err, err_cnt} !== {2'(e_mode), e_sd, e_se, e_te, 8'(e_err)}) begin
        n_bad++;
        $display("FAIL unknown cyc%0d got %0d/%b%b%b/%0d want %0d/%b%b%b/%0d", i,
                 mode, seq_done, step_err, time_err, err_cnt, e_mode, e_sd, e_se, e_te, e_err);
      end
      se_n += int'(step_err); te_n += int'(time_err);
    end
    n_cmp++;
    if (se_n != 1 || te_n != 0 || err_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL unknown_summary got se=%0d te=%0d err=%0d want 1/0/1", se_n, te_n, err_cnt);
    end
  endtask

  task automatic test_timing();
    logic [5:0] q[$];
    int te_n = 0, se_n = 0;
    cyc(OFF, 1'b1);
    repeat (D) q.push_back(L1);
    repeat (D - 1) q.push_back(L2);
    repeat (D) q.push_back(L3);
    repeat (D + 1) q.push_back(OFF);
    repeat (D) q.push_back(L1);
    repeat (D + 1) q.push_back(L2);
    repeat (D + 2) q.push_back(OFF);
    foreach (q[i]) begin
      cyc(q[i], 1'b0);
      n_cmp++;
      if ({mode, seq_done, step_err, time_err, err_cnt} !== {2'(e_mode), e_sd, e_se, e_te, 8'(e_err)}) begin
        n_bad++;
        $display("FAIL timing cyc%0d got %0d/%b%b%b/%0d want %0d/%b%b%b/%0d", i,
                 mode, seq_done, step_err, time_err, err_cnt, e_mode, e_sd, e_se, e_te, e_err);
      end
      te_n += int'(time_err); se_n += int'(step_err);
    end
    n_cmp++;
    if (te_n != 2 || se_n != 0 || err_cnt !== 8'd2) begin
      n_bad++;
      $display("FAIL timing_summary got te=%0d se=%0d err=%0d want 2/0/2", te_n, se_n, err_cnt);
    end
  endtask

  task automatic test_rst_mid();
    logic [5:0] q[$];
    int bad_n = 0;
    cyc(OFF, 1'b1);
    repeat (D) cyc(R1, 1'b0);
    repeat (2) cyc(R2, 1'b0);
    cyc(R2, 1'b1);
    n_cmp++;
    if ({mode, seq_done, step_err, time_err, err_cnt} !== 13'd0) begin
      n_bad++;
      $display("FAIL rst_mid got mode=%0d sd=%b se=%b te=%b err=%0d want all zero",
               mode, seq_done, step_err, time_err, err_cnt);
    end
    repeat (D) q.push_back(R1);
    repeat (D + 2) q.push_back(OFF);
    foreach (q[i]) begin
      cyc(q[i], 1'b0);
      n_cmp++;
      if ({mode, seq_done, step_err, time_err, err_cnt} !== {2'(e_mode), e_sd, e_se, e_te, 8'(e_err)}) begin
        n_bad++;
        $display("FAIL rst_mid cyc%0d got %0d/%b%b%b/%0d want %0d/%b%b%b/%0d", i,
                 mode, seq_done, step_err, time_err, err_cnt, e_mode, e_sd, e_se, e_te, e_err);
      end
      bad_n += int'(step_err) + int'(time_err);
    end
    n_cmp++;
    if (bad_n != 0 || err_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL rst_mid_after got errs=%0d err_cnt=%0d want 0/0", bad_n, err_cnt);
    end
  endtask

  task automatic test_sat();
    logic [5:0] p;
    int s, l, mm = 0;
    cyc(OFF, 1'b1);
    for (int i = 0; i < 300; i++) begin
      do p = 6'($urandom); while (decode(p, s, l));
      cyc(p, 1'b0);
      cyc(OFF, 1'b0);
      if ({mode, step_err, time_err, err_cnt} !== {2'(e_mode), e_se, e_te, 8'(e_err)}) mm++;
    end
    cyc(OFF, 1'b0);
    n_cmp++;
    if (mm != 0) begin n_bad++; $display("FAIL sat_track got %0d bad cycles want 0", mm); end
    n_cmp++;
    if (err_cnt !== 8'd255) begin
      n_bad++;
      $display("FAIL sat_hold got err=%0d want 255", err_cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] pats[8] = '{OFF, L1, L2, L3, R1, R2, R3, ALL};
    logic [5:0] p;
    int len, cnt = 0;
    cyc(OFF, 1'b1);
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(9) == 0) p = 6'($urandom);
      else p = pats[$urandom_range(7)];
      len = ($urandom_range(2) == 0) ? $urandom_range(1, D + 2) : D;
      for (int k = 0; k < len; k++) begin
        cyc(p, ($urandom_range(199) == 0));
        cnt++;
        n_cmp++;
        if ({mode, seq_done, step_err, time_err, err_cnt} !== {2'(e_mode), e_sd, e_se, e_te, 8'(e_err)}) begin
          n_bad++;
          $display("FAIL random cyc%0d p=%b got %0d/%b%b%b/%0d want %0d/%b%b%b/%0d", cnt, p,
                   mode, seq_done, step_err, time_err, err_cnt, e_mode, e_sd, e_se, e_te, e_err);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_left();
    test_haz();
    test_illegal();
    test_unknown();
    test_timing();
    test_rst_mid();
    test_sat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/t_bird_tail_light_decoder.md
T_BIRD_TAIL_LIGHT_DECODER -- requirements
Module: t_bird_tail_light_decoder

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4, int >= 2: clk cycles each non-OFF lamp pattern is held by the tail-light FSM.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports LA LB LC RA RB RC, input, 1 each, observed lamp drives, synchronous to clk; pattern P = {LA,LB,LC,RA,RB,RC}.
REQ-005 SHALL have port mode, output, 2, decoded command: IDLE=0, LEFT=1, RIGHT=2, HAZ=3.
REQ-006 SHALL have ports seq_done, step_err and time_err, output, 1 each, single-cycle pulses.
REQ-007 SHALL have port err_cnt, output, 8, saturating count of step_err plus time_err events.

Function
REQ-008 SHALL treat as legal only: OFF=000_000, L1=100_000, L2=110_000, L3=111_000, R1=000_100, R2=000_110, R3=000_111, ALL=111_111.
REQ-009 SHALL track FSM state in {OFF, L1, L2, L3, R1, R2, R3, ALL, UNKNOWN}; reset state OFF.
REQ-010 SHALL allow these transitions (self-loops always legal): OFF->{L1,R1,ALL}; L1->L2; L2->L3; R1->R2; R2->R3; any legal pattern->OFF.
REQ-011 SHALL, on an illegal code or a disallowed transition, pulse step_err and enter UNKNOWN; UNKNOWN is left only on OFF, with no further step_err while in UNKNOWN.
REQ-012 SHALL keep dwell counter cnt = consecutive cycles P has been sampled: 1 on a change, saturating at DWELL_CYCLES+1.
REQ-013 SHALL pulse time_err when a non-OFF pattern changes to another non-OFF pattern with cnt != DWELL_CYCLES.
REQ-014 SHALL pulse time_err once when a non-OFF pattern reaches cnt = DWELL_CYCLES+1.
REQ-015 SHALL NOT flag time_err for an early change to OFF; this is an upstream abort or reset.
REQ-016 SHALL set mode, on the first sample of L1, R1 or ALL, to LEFT, RIGHT or HAZ respectively.
REQ-017 SHALL return mode to IDLE when OFF reaches cnt = DWELL_CYCLES+1, or on entry to UNKNOWN.
REQ-018 SHALL pulse seq_done on transitions L3->OFF, R3->OFF and ALL->OFF.
REQ-019 SHALL register all outputs with 1-cycle latency: the response to the sample at edge n is visible after edge n+1.
REQ-020 SHALL, when step_err and time_err fire in the same cycle, raise both pulses and increment err_cnt by 2, saturating at 255.

Reset
REQ-021 SHALL, with rst high at an edge, set mode=IDLE, seq_done=0, step_err=0, time_err=0, err_cnt=0, state=OFF, cnt=0.
REQ-022 SHALL apply rst mid-sequence with priority over all inputs, with no error raised for the interrupted sequence.
REQ-023 SHALL treat the first sampled pattern after reset as a new pattern (cnt=1), checked against state OFF.

Structure
REQ-024 SHALL place the lamp_pat_e enum (6-bit codes from REQ-008), the mode_e enum and the decoder state enum in a shared package t_bird_tail_light_pkg.
REQ-025 SHALL instantiate one sub-module, t_bird_dwell_counter (pattern-change detect plus saturating counter); all other logic stays in the top.

Verification (DWELL_CYCLES=4)
REQ-026 SHALL cover: L1,L2,L3,OFF each 4 cycles -> mode=LEFT from the cycle after first L1, one seq_done after OFF, err_cnt=0, mode=IDLE after 5 OFF cycles.
REQ-027 SHALL cover: ALL/OFF alternating, 4 cycles each, 3 periods -> mode=HAZ throughout, 3 seq_done pulses, no errors.
REQ-028 SHALL cover: P=101_000 for 1 cycle, then OFF -> one step_err, mode=IDLE, err_cnt=1, state OFF afterwards.
REQ-029 SHALL cover: R1 (4 cycles) then R3 -> step_err and UNKNOWN; then R2 -> no further step_err.
REQ-030 SHALL cover: L1 4 cycles, L2 3 cycles, L3 -> time_err at the L3 change; L2 held 5 cycles -> single time_err.
REQ-031 SHALL cover: rst during R2 -> all outputs cleared next cycle; forcing 300 errors -> err_cnt holds 255.
